// File: rtl/lanes_deserializer.sv
// Two-lane serial-to-parallel converter for the receive path.
// Builds 8-bit MSB-first symbols (Gen4) or 132/66-bit LSB-first blocks
// (Gen3/Gen2). Each finished word gets a one-cycle valid pulse and a
// descrambler seed reset.
module lanes_deserializer #(
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_deser,
  input  logic             lane_0_rx_ser,
  input  logic             lane_1_rx_ser,
  input  logic [1:0]       gen_speed,
  input  logic             bit_slip,
  output logic [WIDTH-1:0] lane_0_rx_parallel,
  output logic [WIDTH-1:0] lane_1_rx_parallel,
  output logic             parallel_valid,
  output logic             descr_rst,
  output logic             enable_descr
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [CW-1:0]    count_max;
  logic [CW-1:0]    bit_idx;
  logic             msb_first;
  logic             last_bit;
  logic [WIDTH-1:0] asm0;
  logic [WIDTH-1:0] asm1;
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] word_mask;
  logic [WIDTH-1:0] merged0;
  logic [WIDTH-1:0] merged1;

  // Word size and bit order follow the generation speed (11 behaves as Gen4)
  always_comb begin
    count_max = CW'(8);
    msb_first = 1'b1;
    case (gen_speed)
      2'b01: begin
        count_max = CW'(132);
        msb_first = 1'b0;
      end
      2'b10: begin
        count_max = CW'(66);
        msb_first = 1'b0;
      end
      default: ;
    endcase
  end

  // One-hot write position, valid-bit mask and the words with this cycle's bit merged in.
  // A Gen4 count beyond 7 only happens after a mid-word speed drop; no bit is placed then.
  always_comb begin
    bit_idx   = count;
    bit_sel   = '0;
    word_mask = '0;
    if (msb_first) begin
      bit_idx = CW'(7) - count;
    end
    if (!(msb_first && (count > CW'(7)))) begin
      bit_sel = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
    end
    for (int i = 0; i < WIDTH; i++) begin
      word_mask[i] = (CW'(i) < count_max);
    end
    merged0  = asm0 | (lane_0_rx_ser ? bit_sel : '0);
    merged1  = asm1 | (lane_1_rx_ser ? bit_sel : '0);
    last_bit = (count >= (count_max - CW'(1)));
  end

  // Shift-in, word completion and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count              <= '0;
      asm0               <= '0;
      asm1               <= '0;
      lane_0_rx_parallel <= '0;
      lane_1_rx_parallel <= '0;
      parallel_valid     <= 1'b0;
      descr_rst          <= 1'b0;
      enable_descr       <= 1'b0;
    end else if (!enable_deser) begin
      count              <= '0;
      asm0               <= '0;
      asm1               <= '0;
      lane_0_rx_parallel <= '0;
      lane_1_rx_parallel <= '0;
      parallel_valid     <= 1'b0;
      descr_rst          <= 1'b0;
      enable_descr       <= 1'b0;
    end else if (bit_slip) begin
      parallel_valid <= 1'b0;
      descr_rst      <= 1'b0;
      enable_descr   <= 1'b1;
    end else begin
      enable_descr <= 1'b1;
      if (last_bit) begin
        lane_0_rx_parallel <= merged0 & word_mask;
        lane_1_rx_parallel <= merged1 & word_mask;
        asm0               <= '0;
        asm1               <= '0;
        count              <= '0;
        parallel_valid     <= 1'b1;
        descr_rst          <= 1'b1;
      end else begin
        asm0           <= merged0;
        asm1           <= merged1;
        count          <= count + CW'(1);
        parallel_valid <= 1'b0;
        descr_rst      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lanes_deserializer.sv
// Randomised scoreboard bench for lanes_deserializer.
// Words are described as parallel values; the bench serialises them in
// transmission order and expects them back at a predicted cycle.
module tb_lanes_deserializer;

  localparam int W = 132;

  typedef struct {
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable_deser = 1'b0;
  logic         lane_0_rx_ser = 1'b0;
  logic         lane_1_rx_ser = 1'b0;
  logic [1:0]   gen_speed = 2'b00;
  logic         bit_slip = 1'b0;
  logic [W-1:0] lane_0_rx_parallel;
  logic [W-1:0] lane_1_rx_parallel;
  logic         parallel_valid;
  logic         descr_rst;
  logic         enable_descr;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  lanes_deserializer #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_deser      (enable_deser),
    .lane_0_rx_ser     (lane_0_rx_ser),
    .lane_1_rx_ser     (lane_1_rx_ser),
    .gen_speed         (gen_speed),
    .bit_slip          (bit_slip),
    .lane_0_rx_parallel(lane_0_rx_parallel),
    .lane_1_rx_parallel(lane_1_rx_parallel),
    .parallel_valid    (parallel_valid),
    .descr_rst         (descr_rst),
    .enable_descr      (enable_descr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cmax(input logic [1:0] gen);
    case (gen)
      2'b01:   return 132;
      2'b10:   return 66;
      default: return 8;
    endcase
  endfunction

  function automatic logic [W-1:0] maskOf(input int n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected word at the predicted cycle
  always @(negedge clk) begin
    if (parallel_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", W'(parallel_valid), '0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("lane0_word", lane_0_rx_parallel, mon_e.w0);
        checkOutput("lane1_word", lane_1_rx_parallel, mon_e.w1);
        checkOutput("valid_cycle", W'(cyc), W'(mon_e.cyc));
        checkOutput("descr_rst_pulse", W'(descr_rst), W'(1));
      end
    end else begin
      checkOutput("descr_rst_idle", W'(descr_rst), '0);
    end
  end

  // Serialise one word per lane; optional slip cycle inserted before bit slip_pos
  task automatic applyStimulus(input logic [1:0] gen, input logic [W-1:0] w0in,
                               input logic [W-1:0] w1in, input int slip_pos,
                               input bit check_hold, input logic [W-1:0] h0,
                               input logic [W-1:0] h1);
    int           n;
    int           total;
    bit           first;
    bit           msb;
    exp_t         e;
    n       = cmax(gen);
    msb     = (n == 8);
    total   = n + ((slip_pos >= 0) ? 1 : 0);
    e.w0    = w0in & maskOf(n);
    e.w1    = w1in & maskOf(n);
    first   = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == slip_pos) begin
        @(negedge clk);
        if (first) begin
          e.cyc = cyc + total;
          sb.push_back(e);
          first = 1'b0;
        end
        enable_deser  = 1'b1;
        gen_speed     = gen;
        bit_slip      = 1'b1;
        lane_0_rx_ser = 1'($urandom);
        lane_1_rx_ser = 1'($urandom);
      end
      @(negedge clk);
      if (first) begin
        e.cyc = cyc + total;
        sb.push_back(e);
        first = 1'b0;
      end
      if (check_hold && k == 60) begin
        checkOutput("hold_lane0", lane_0_rx_parallel, h0);
        checkOutput("hold_lane1", lane_1_rx_parallel, h1);
      end
      if (k == 1) checkOutput("enable_descr_on", W'(enable_descr), W'(1));
      enable_deser  = 1'b1;
      gen_speed     = gen;
      bit_slip      = 1'b0;
      lane_0_rx_ser = msb ? e.w0[7-k] : e.w0[k];
      lane_1_rx_ser = msb ? e.w1[7-k] : e.w1[k];
    end
  endtask

  task automatic sendPartial(input logic [1:0] gen, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      enable_deser  = 1'b1;
      gen_speed     = gen;
      bit_slip      = 1'b0;
      lane_0_rx_ser = 1'($urandom);
      lane_1_rx_ser = 1'($urandom);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      enable_deser = 1'b0;
      bit_slip     = 1'b0;
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_lane0"}, lane_0_rx_parallel, '0);
    checkOutput({tag, "_lane1"}, lane_1_rx_parallel, '0);
    checkOutput({tag, "_valid"}, W'(parallel_valid), '0);
    checkOutput({tag, "_enable_descr"}, W'(enable_descr), '0);
  endtask

  // Directed scenarios followed by a randomised run
  initial begin
    logic [W-1:0] r0, r1, p0, p1;
    logic [1:0]   g;
    int           sp;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkCleared("reset");
    checkOutput("reset_descr_rst", W'(descr_rst), '0);
    rst = 1'b1;

    $display("[TB] Gen4 directed symbol");
    applyStimulus(2'b00, W'(8'hA5), W'(8'h3C), -1, 1'b0, '0, '0);
    idleCycles(2);

    $display("[TB] Gen2 directed block");
    applyStimulus(2'b10, W'(66'h2_AAAA_AAAA_AAAA_AAAA), W'({66{1'b1}}), -1, 1'b0, '0, '0);
    idleCycles(2);

    $display("[TB] Gen3 back-to-back blocks");
    p0 = '0;
    p1 = '0;
    for (int i = 0; i < 3; i++) begin
      r0 = rnd();
      r1 = rnd();
      applyStimulus(2'b01, r0, r1, -1, (i > 0), p0, p1);
      p0 = r0 & maskOf(132);
      p1 = r1 & maskOf(132);
    end
    idleCycles(2);

    $display("[TB] Gen4 bit slip");
    applyStimulus(2'b00, W'(8'h81), W'(8'h81), 0, 1'b0, '0, '0);
    idleCycles(2);

    $display("[TB] Mid-word abort");
    sendPartial(2'b01, 40);
    idleCycles(1);
    @(negedge clk);
    checkCleared("abort");
    applyStimulus(2'b01, rnd(), rnd(), -1, 1'b0, '0, '0);

    $display("[TB] Async reset mid-word");
    sendPartial(2'b10, 30);
    #2 rst = 1'b0;
    #1 checkCleared("async_reset");
    @(negedge clk);
    rst          = 1'b1;
    enable_deser = 1'b0;
    applyStimulus(2'b10, rnd(), rnd(), -1, 1'b0, '0, '0);

    $display("[TB] Randomised words");
    for (int i = 0; i < 12; i++) begin
      g  = 2'($urandom_range(0, 3));
      sp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cmax(g) - 1) : -1;
      applyStimulus(g, rnd(), rnd(), sp, 1'b0, '0, '0);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end
    idleCycles(4);
    checkOutput("scoreboard_drained", W'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total run time
  initial begin
    #1000000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lanes_deserializer.md
Name: lanes_deserializer

Overview:
Receive-side counterpart of the lanes serializer. Samples the two serial RX lanes one bit per clk and assembles the bits into parallel words whose size depends on gen speed: 8-bit MSB-first symbols for Gen4, 132-bit or 66-bit LSB-first blocks for Gen3 and Gen2. Each completed word is presented with a one-cycle valid pulse, together with a word-boundary pulse that resets the descrambler seed. Sits between the lane RX front end and the lane descramblers.

Parameters:
WIDTH, 132, width of the parallel output words; must be at least 132.

Ports:
clk  input  1  bit clock, one serial bit per lane per cycle
rst  input  1  asynchronous, active-low reset
enable_deser  input  1  deserializer enable; its rising edge defines the word boundary
lane_0_rx_ser  input  1  lane 0 serial data
lane_1_rx_ser  input  1  lane 1 serial data
gen_speed  input  2  00 = Gen4, 01 = Gen3, 10 = Gen2, 11 = treated as Gen4
bit_slip  input  1  discard the current bit on both lanes; used for word alignment
lane_0_rx_parallel  output  WIDTH  lane 0 assembled word
lane_1_rx_parallel  output  WIDTH  lane 1 assembled word
parallel_valid  output  1  one-cycle pulse when a new word is on the parallel outputs
descr_rst  output  1  descrambler seed reset; pulses with parallel_valid
enable_descr  output  1  descrambler enable

Behaviour:
- Word size (count_max): Gen4 = 8, Gen3 = 132, Gen2 = 66, 11 = 8. Decoded combinationally from gen_speed.
- Counter: count, $clog2(WIDTH) bits wide.
- Assembly registers: asm0 and asm1, each WIDTH bits.
- Reset (rst = 0, asynchronous): every register and output is 0, including count, asm0/asm1, both parallel outputs, parallel_valid, descr_rst and enable_descr.
- enable_deser = 0 (synchronous):
  - count <= 0; asm0/asm1 <= 0; both parallel outputs <= 0.
  - parallel_valid, descr_rst and enable_descr <= 0.
- enable_deser = 1, bit_slip = 1:
  - The lane bits of this cycle are dropped.
  - count, asm0/asm1 and the parallel outputs hold.
  - parallel_valid and descr_rst are 0; enable_descr is 1.
- enable_deser = 1, bit_slip = 0: sample both lanes at the rising edge.
  - Bit index: Gen4 writes bit position 7-count, so the first received bit is the MSB. Gen3/Gen2 write bit position count, so the first received bit is bit 0.
  - Not last bit (count < count_max-1): write the sampled bit into asm0/asm1 at the index; count <= count+1; parallel_valid <= 0; descr_rst <= 0.
  - Last bit (count >= count_max-1):
    - lane_x_rx_parallel <= asmx with the current bit merged in; bits at or above count_max are 0.
    - asmx <= 0; count <= 0.
    - parallel_valid <= 1 and descr_rst <= 1 for exactly one cycle.
  - enable_descr <= 1.
- Latency: the word is on the outputs in the cycle after the edge that sampled its last bit. Back-to-back words produce one parallel_valid every count_max enabled, non-slipped cycles.
- Parallel outputs hold their value between valid pulses.
- Wrap-around: the ">=" compare forces a word boundary if gen_speed is lowered mid-word (count already past the new count_max-1). The partial word is emitted with the current bit included. gen_speed is required to be static while enable_deser = 1; this rule only prevents lock-up.
- Lane alignment: both lanes always share count and slip together; there is no per-lane skew handling.
- Reset or disable mid-word discards the partial word and emits no valid pulse. The next enabled cycle samples bit 0 of a new word.
- Loopback with lanes_serializer: the serializer drives its first loaded bit one cycle after its enable rises. enable_deser must therefore rise one cycle after enable_ser for the two to be word-aligned.

Test Plan:
- Gen4: after enable, drive lane0 = 0xA5 and lane1 = 0x3C MSB-first over 8 cycles -> parallel_valid pulses once; lane_0_rx_parallel = 0xA5 and lane_1_rx_parallel = 0x3C, upper bits 0; descr_rst pulses in the same cycle.
- Gen2: drive 66 bits LSB-first, lane0 bit i = i[0] (alternating 0,1) and lane1 all 1 -> lane_0_rx_parallel[65:0] = 66'h2_AAAA_AAAA_AAAA_AAAA; lane_1_rx_parallel[65:0] all ones; bits [131:66] = 0.
- Gen3 back-to-back: three consecutive 132-bit words -> valid pulses exactly 132 cycles apart; each word matches the driven data; outputs hold between pulses.
- bit_slip: Gen4, one junk bit then 0x81, with bit_slip high only during the junk cycle -> output 0x81 one cycle later than without slip; no extra valid pulse.
- Mid-word abort: deassert enable_deser after 40 of 132 bits -> no valid pulse; all outputs 0; enable_descr 0. Re-enable and send a full word -> that word is correct.
- Async reset: assert rst mid-word in Gen2 between clock edges -> all outputs 0 immediately. After release, a full 66-bit word decodes correctly.
- Loopback: lanes_serializer feeding lanes_deserializer with enable skewed by 1 cycle, random Gen4, Gen3 and Gen2 words -> recovered words equal the transmitted words; descr_rst is aligned with the serializer's scr_rst plus a fixed offset.
